// File: rtl/riscv_imem.sv
// Instruction-memory responder for the fetch link: one outstanding request, fixed wait
// states, response held until acknowledged, plus an independent loader write port.
module riscv_imem #(
  parameter int unsigned BUS_WIDTH  = 32,
  parameter int unsigned DEPTH_LOG2 = 8,
  parameter int unsigned LATENCY    = 2
) (
  input  logic                 i_CLK,
  input  logic                 i_RST_N,
  input  logic                 i_REQ,
  input  logic [BUS_WIDTH-1:0] i_ADDR,
  output logic                 o_GNT,
  output logic                 o_RVALID,
  output logic [BUS_WIDTH-1:0] o_DATA,
  output logic                 o_ERR,
  input  logic                 i_RACK,
  input  logic                 i_WE,
  input  logic [BUS_WIDTH-1:0] i_WADDR,
  input  logic [BUS_WIDTH-1:0] i_WDATA
);

  localparam int unsigned Depth = 2 ** DEPTH_LOG2;
  localparam int unsigned CntW  = 4;
  localparam int          WaitLoadInt = (LATENCY > 1) ? int'(LATENCY) - 2 : 0;
  localparam logic [CntW-1:0] WaitLoad = CntW'(WaitLoadInt);

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e                 state_q, state_d;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic [BUS_WIDTH-1:0]   addr_q, addr_d;
  logic [BUS_WIDTH-1:0]   data_q, data_d;
  logic                   rvalid_q, rvalid_d;
  logic                   err_q, err_d;
  logic                   enter_resp;
  logic [BUS_WIDTH-1:0]   rd_addr;
  logic [DEPTH_LOG2-1:0]  rd_idx;
  logic                   rd_fault;
  logic [DEPTH_LOG2-1:0]  wr_idx;
  logic                   unused_waddr;

  logic [BUS_WIDTH-1:0] mem_q [Depth];

  assign wr_idx       = i_WADDR[DEPTH_LOG2+1:2];
  assign unused_waddr = ^{i_WADDR[1:0], i_WADDR[BUS_WIDTH-1:DEPTH_LOG2+2]};

  // Writes ignore reset and state; nonblocking update gives read-before-write on a shared edge.
  always_ff @(posedge i_CLK) begin
    if (i_WE) begin
      mem_q[wr_idx] <= i_WDATA;
    end
  end

  // With LATENCY==1 the read happens on the acceptance edge, so it must use the live address.
  assign rd_addr  = (state_q == StIdle) ? i_ADDR : addr_q;
  assign rd_idx   = rd_addr[DEPTH_LOG2+1:2];
  assign rd_fault = (rd_addr[1:0] != 2'b00) || (rd_addr[BUS_WIDTH-1:DEPTH_LOG2+2] != '0);

  assign o_GNT    = (state_q == StIdle) && i_RST_N;
  assign o_RVALID = rvalid_q;
  assign o_DATA   = data_q;
  assign o_ERR    = err_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    data_d     = data_q;
    rvalid_d   = rvalid_q;
    err_d      = err_q;
    enter_resp = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (i_REQ) begin
          addr_d = i_ADDR;
          if (LATENCY == 1) begin
            state_d    = StResp;
            enter_resp = 1'b1;
          end else begin
            cnt_d   = WaitLoad;
            state_d = StWait;
          end
        end
      end
      StWait: begin
        if (cnt_q == '0) begin
          state_d    = StResp;
          enter_resp = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StResp: begin
        if (i_RACK) begin
          rvalid_d = 1'b0;
          err_d    = 1'b0;
          state_d  = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    if (enter_resp) begin
      rvalid_d = 1'b1;
      err_d    = rd_fault;
      data_d   = rd_fault ? '0 : mem_q[rd_idx];
    end
  end

  always_ff @(posedge i_CLK) begin
    if (!i_RST_N) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      addr_q   <= '0;
      data_q   <= '0;
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      rvalid_q <= rvalid_d;
      err_q    <= err_d;
    end
  end

endmodule
